// File: rtl/pixel_range_clamp.sv
// pixel_range_clamp
//   Streaming pixel conditioner. Each accepted beat carries CHANNELS pixels of
//   RAW_BITS each. Every pixel is passed through, zero-replaced (0 -> 1) or
//   clamped into [min, max], depending on a per-frame configuration. The
//   configuration is latched at frame start. The block also counts the pixels
//   that were clipped low and high, and reports both counts once per frame.
//
// Ports
//   aclk_i, areset_i, aclken_i        clock, async active-high reset, clock enable
//   mode_i, clip_min_i, clip_max_i    live configuration, sampled at frame start
//   s_t*_i / s_tready_o               input stream (tuser[0] marks frame start)
//   m_t*_o / m_tready_i               output stream, one register stage
//   stat_low_o, stat_high_o           clip counts of the last completed frame
//   stat_valid_o                      one-cycle pulse when the stats update
module pixel_range_clamp #(
  parameter int CHANNELS   = 4,
  parameter int RAW_BITS   = 10,
  parameter int USER_BITS  = 1,
  parameter int COUNT_BITS = 24
) (
  input  logic                         aclk_i,
  input  logic                         areset_i,
  input  logic                         aclken_i,
  input  logic [1:0]                   mode_i,
  input  logic [RAW_BITS-1:0]          clip_min_i,
  input  logic [RAW_BITS-1:0]          clip_max_i,
  input  logic [USER_BITS-1:0]         s_tuser_i,
  input  logic                         s_tlast_i,
  input  logic [CHANNELS*RAW_BITS-1:0] s_tdata_i,
  input  logic                         s_tvalid_i,
  output logic                         s_tready_o,
  output logic [USER_BITS-1:0]         m_tuser_o,
  output logic                         m_tlast_o,
  output logic [CHANNELS*RAW_BITS-1:0] m_tdata_o,
  output logic                         m_tvalid_o,
  input  logic                         m_tready_i,
  output logic [COUNT_BITS-1:0]        stat_low_o,
  output logic [COUNT_BITS-1:0]        stat_high_o,
  output logic                         stat_valid_o
);

  localparam int DW = CHANNELS * RAW_BITS;
  localparam int CW = $clog2(CHANNELS + 1);
  localparam int SW = COUNT_BITS + CW;
  localparam logic [COUNT_BITS-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_ZERO   = 2'd1,
    MODE_CLAMP  = 2'd2,
    MODE_CLAMP2 = 2'd3
  } modeE;

  logic [DW-1:0]         mData_q;
  logic [USER_BITS-1:0]  mUser_q;
  logic                  mLast_q;
  logic                  mValid_q;
  modeE                  modeShadow_q;
  logic [RAW_BITS-1:0]   minShadow_q;
  logic [RAW_BITS-1:0]   maxShadow_q;
  logic                  capturePending_q;
  logic [COUNT_BITS-1:0] cntLow_q, cntLow_d;
  logic [COUNT_BITS-1:0] cntHigh_q, cntHigh_d;
  logic [COUNT_BITS-1:0] statLow_q, statLow_d;
  logic [COUNT_BITS-1:0] statHigh_q, statHigh_d;
  logic                  statValid_q;

  logic                  load;
  logic                  accept;
  logic                  sof;
  logic                  useLive;
  modeE                  effMode;
  logic [RAW_BITS-1:0]   effMin;
  logic [RAW_BITS-1:0]   effMax;
  logic [DW-1:0]         procData_d;
  logic [CHANNELS-1:0]   lowFlags;
  logic [CHANNELS-1:0]   highFlags;
  logic [CW-1:0]         lowCount;
  logic [CW-1:0]         highCount;

  // Adds a per-beat clip count to a running counter, pinning at all-ones.
  function automatic logic [COUNT_BITS-1:0] satAdd(input logic [COUNT_BITS-1:0] a,
                                                  input logic [CW-1:0] b);
    logic [SW-1:0] sum;
    sum = SW'(a) + SW'(b);
    if (sum > SW'(CNT_MAX)) return CNT_MAX;
    return sum[COUNT_BITS-1:0];
  endfunction

  // Single-stage skid-less pipeline: the input may advance whenever the
  // output register is empty or is being drained this cycle.
  assign s_tready_o = !mValid_q || m_tready_i;
  assign load       = aclken_i && s_tready_o;
  assign accept     = load && s_tvalid_i;
  assign sof        = accept && s_tuser_i[0];

  // A frame-start beat, and the first enabled cycle after reset, work with the
  // live configuration. That is the same value that gets latched into the
  // shadows on that cycle.
  assign useLive = s_tuser_i[0] || capturePending_q;

  // Per-channel pixel processing and clip classification.
  always_comb begin
    effMode    = useLive ? modeE'(mode_i) : modeShadow_q;
    effMin     = useLive ? clip_min_i : minShadow_q;
    effMax     = useLive ? clip_max_i : maxShadow_q;
    procData_d = s_tdata_i;
    lowFlags   = '0;
    highFlags  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      case (effMode)
        MODE_ZERO: begin
          if (s_tdata_i[i*RAW_BITS +: RAW_BITS] == '0) begin
            procData_d[i*RAW_BITS +: RAW_BITS] = RAW_BITS'(1);
            lowFlags[i] = 1'b1;
          end
        end
        MODE_CLAMP, MODE_CLAMP2: begin
          // The low test wins, so an inverted range (min > max) is still well defined.
          if (s_tdata_i[i*RAW_BITS +: RAW_BITS] < effMin) begin
            procData_d[i*RAW_BITS +: RAW_BITS] = effMin;
            lowFlags[i] = 1'b1;
          end else if (s_tdata_i[i*RAW_BITS +: RAW_BITS] > effMax) begin
            procData_d[i*RAW_BITS +: RAW_BITS] = effMax;
            highFlags[i] = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Population count of the clip flags for this beat.
  always_comb begin
    lowCount  = '0;
    highCount = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      lowCount  = lowCount + CW'(lowFlags[i]);
      highCount = highCount + CW'(highFlags[i]);
    end
  end

  // Statistics next state. A frame start publishes the running totals and
  // restarts the counters with only the frame-start beat's own clips.
  always_comb begin
    cntLow_d   = cntLow_q;
    cntHigh_d  = cntHigh_q;
    statLow_d  = statLow_q;
    statHigh_d = statHigh_q;
    if (sof) begin
      statLow_d  = cntLow_q;
      statHigh_d = cntHigh_q;
      cntLow_d   = satAdd('0, lowCount);
      cntHigh_d  = satAdd('0, highCount);
    end else if (accept) begin
      cntLow_d   = satAdd(cntLow_q, lowCount);
      cntHigh_d  = satAdd(cntHigh_q, highCount);
    end
  end

  // All state registers. When aclken is low, every register holds its value,
  // including the stat_valid pulse.
  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      mData_q          <= '0;
      mUser_q          <= '0;
      mLast_q          <= 1'b0;
      mValid_q         <= 1'b0;
      modeShadow_q     <= MODE_BYPASS;
      minShadow_q      <= '0;
      maxShadow_q      <= '1;
      capturePending_q <= 1'b1;
      cntLow_q         <= '0;
      cntHigh_q        <= '0;
      statLow_q        <= '0;
      statHigh_q       <= '0;
      statValid_q      <= 1'b0;
    end else if (aclken_i) begin
      if (load) begin
        mValid_q <= s_tvalid_i;
        mData_q  <= procData_d;
        mUser_q  <= s_tuser_i;
        mLast_q  <= s_tlast_i;
      end
      if (sof || capturePending_q) begin
        modeShadow_q <= modeE'(mode_i);
        minShadow_q  <= clip_min_i;
        maxShadow_q  <= clip_max_i;
      end
      capturePending_q <= 1'b0;
      cntLow_q         <= cntLow_d;
      cntHigh_q        <= cntHigh_d;
      statLow_q        <= statLow_d;
      statHigh_q       <= statHigh_d;
      statValid_q      <= sof;
    end
  end

  assign m_tdata_o    = mData_q;
  assign m_tuser_o    = mUser_q;
  assign m_tlast_o    = mLast_q;
  assign m_tvalid_o   = mValid_q;
  assign stat_low_o   = statLow_q;
  assign stat_high_o  = statHigh_q;
  assign stat_valid_o = statValid_q;

endmodule

// File: tb/tb_pixel_range_clamp.sv
// tb_pixel_range_clamp
//   Directed bench for pixel_range_clamp. A default-sized instance and a
//   COUNT_BITS=4 instance share all inputs. The narrow instance exposes
//   counter saturation.
module tb_pixel_range_clamp;

  logic        aclk;
  logic        areset;
  logic        aclken;
  logic [1:0]  mode;
  logic [9:0]  clipMin;
  logic [9:0]  clipMax;
  logic [0:0]  sTuser;
  logic        sTlast;
  logic [39:0] sTdata;
  logic        sTvalid;
  logic        mTready;

  logic        sTready;
  logic [0:0]  mTuser;
  logic        mTlast;
  logic [39:0] mTdata;
  logic        mTvalid;
  logic [23:0] statLow;
  logic [23:0] statHigh;
  logic        statValid;

  logic        sTreadySat;
  logic [0:0]  mTuserSat;
  logic        mTlastSat;
  logic [39:0] mTdataSat;
  logic        mTvalidSat;
  logic [3:0]  statLowSat;
  logic [3:0]  statHighSat;
  logic        statValidSat;

  int assertCount = 0;
  int failCount   = 0;

  pixel_range_clamp dut (
    .aclk_i(aclk), .areset_i(areset), .aclken_i(aclken), .mode_i(mode),
    .clip_min_i(clipMin), .clip_max_i(clipMax),
    .s_tuser_i(sTuser), .s_tlast_i(sTlast), .s_tdata_i(sTdata), .s_tvalid_i(sTvalid),
    .s_tready_o(sTready),
    .m_tuser_o(mTuser), .m_tlast_o(mTlast), .m_tdata_o(mTdata), .m_tvalid_o(mTvalid),
    .m_tready_i(mTready),
    .stat_low_o(statLow), .stat_high_o(statHigh), .stat_valid_o(statValid)
  );

  pixel_range_clamp #(.COUNT_BITS(4)) dutSat (
    .aclk_i(aclk), .areset_i(areset), .aclken_i(aclken), .mode_i(mode),
    .clip_min_i(clipMin), .clip_max_i(clipMax),
    .s_tuser_i(sTuser), .s_tlast_i(sTlast), .s_tdata_i(sTdata), .s_tvalid_i(sTvalid),
    .s_tready_o(sTreadySat),
    .m_tuser_o(mTuserSat), .m_tlast_o(mTlastSat), .m_tdata_o(mTdataSat), .m_tvalid_o(mTvalidSat),
    .m_tready_i(mTready),
    .stat_low_o(statLowSat), .stat_high_o(statHighSat), .stat_valid_o(statValidSat)
  );

  // Free-running clock.
  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  // Packs four pixels with pixel 0 in the least significant slot.
  function automatic logic [39:0] pk(input int p0, input int p1, input int p2, input int p3);
    return {10'(p3), 10'(p2), 10'(p1), 10'(p0)};
  endfunction

  // Advances one clock edge and then moves away from it for sampling.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drives one input beat. The beat takes effect at the next edge.
  task automatic applyStimulus(input logic valid, input logic [39:0] data,
                               input logic user, input logic last);
    sTvalid = valid;
    sTdata  = data;
    sTuser  = user;
    sTlast  = last;
  endtask

  // Reset state, and the ready output held high while reset is asserted.
  task automatic test_reset();
    areset = 1'b1; aclken = 1'b1; mTready = 1'b1;
    mode = 2'd0; clipMin = 10'd0; clipMax = 10'd1023;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick(); tick();
    assertCount++; if (mTvalid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_mvalid: got %0b expected 0", mTvalid); end
    assertCount++; if (sTready !== 1'b1) begin failCount++; $display("[TB] FAIL reset_sready: got %0b expected 1", sTready); end
    assertCount++; if (statValid !== 1'b0) begin failCount++; $display("[TB] FAIL reset_statvalid: got %0b expected 0", statValid); end
    assertCount++; if (mTdata !== 40'd0) begin failCount++; $display("[TB] FAIL reset_mdata: got %h expected 0", mTdata); end
    assertCount++; if (statLow !== 24'd0 || statHigh !== 24'd0) begin failCount++; $display("[TB] FAIL reset_stats: got %0d/%0d expected 0/0", statLow, statHigh); end
    areset = 1'b0;
    tick();
  endtask

  // Bypass mode, plus register hold while the clock enable is low.
  task automatic test_bypass();
    applyStimulus(1'b1, pk(0, 1, 512, 1023), 1'b1, 1'b0);
    tick();
    assertCount++; if (mTvalid !== 1'b1) begin failCount++; $display("[TB] FAIL bypass_mvalid: got %0b expected 1", mTvalid); end
    assertCount++; if (mTdata !== pk(0, 1, 512, 1023)) begin failCount++; $display("[TB] FAIL bypass_data: got %h expected %h", mTdata, pk(0, 1, 512, 1023)); end
    assertCount++; if (mTuser !== 1'b1) begin failCount++; $display("[TB] FAIL bypass_tuser: got %0b expected 1", mTuser); end
    assertCount++; if (statValid !== 1'b1 || statLow !== 24'd0 || statHigh !== 24'd0) begin failCount++; $display("[TB] FAIL first_sof_stats: got v=%0b %0d/%0d expected v=1 0/0", statValid, statLow, statHigh); end
    aclken = 1'b0;
    applyStimulus(1'b1, pk(9, 9, 9, 9), 1'b0, 1'b1);
    tick();
    assertCount++; if (mTdata !== pk(0, 1, 512, 1023) || mTlast !== 1'b0) begin failCount++; $display("[TB] FAIL clken_hold_data: got %h last=%0b expected %h last=0", mTdata, mTlast, pk(0, 1, 512, 1023)); end
    assertCount++; if (statValid !== 1'b1) begin failCount++; $display("[TB] FAIL clken_hold_statvalid: got %0b expected 1", statValid); end
    aclken = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
    assertCount++; if (mTvalid !== 1'b0 || statValid !== 1'b0) begin failCount++; $display("[TB] FAIL bypass_idle: got mvalid=%0b statvalid=%0b expected 0/0", mTvalid, statValid); end
  endtask

  // Zero replacement. The stats published here belong to the bypass frame, which does not count clips.
  task automatic test_zero_replace();
    mode = 2'd1;
    applyStimulus(1'b1, pk(0, 0, 5, 0), 1'b1, 1'b1);
    tick();
    assertCount++; if (mTdata !== pk(1, 1, 5, 1)) begin failCount++; $display("[TB] FAIL zero_data: got %h expected %h", mTdata, pk(1, 1, 5, 1)); end
    assertCount++; if (mTlast !== 1'b1) begin failCount++; $display("[TB] FAIL zero_tlast: got %0b expected 1", mTlast); end
    assertCount++; if (statValid !== 1'b1 || statLow !== 24'd0 || statHigh !== 24'd0) begin failCount++; $display("[TB] FAIL bypass_frame_stats: got v=%0b %0d/%0d expected v=1 0/0", statValid, statLow, statHigh); end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  // Two-beat clamp frame. A mode change in the middle of the frame must not take effect.
  task automatic test_clamp();
    mode = 2'd2; clipMin = 10'd64; clipMax = 10'd960;
    applyStimulus(1'b1, pk(0, 64, 961, 1023), 1'b1, 1'b0);
    tick();
    assertCount++; if (mTdata !== pk(64, 64, 960, 960)) begin failCount++; $display("[TB] FAIL clamp_beat1: got %h expected %h", mTdata, pk(64, 64, 960, 960)); end
    assertCount++; if (statValid !== 1'b1 || statLow !== 24'd3 || statHigh !== 24'd0) begin failCount++; $display("[TB] FAIL zero_frame_stats: got v=%0b %0d/%0d expected v=1 3/0", statValid, statLow, statHigh); end
    mode = 2'd0;
    applyStimulus(1'b1, pk(500, 63, 960, 2), 1'b0, 1'b1);
    tick();
    assertCount++; if (mTdata !== pk(500, 64, 960, 64)) begin failCount++; $display("[TB] FAIL clamp_beat2: got %h expected %h", mTdata, pk(500, 64, 960, 64)); end
    assertCount++; if (statValid !== 1'b0) begin failCount++; $display("[TB] FAIL statvalid_one_cycle: got %0b expected 0", statValid); end
    mode = 2'd2;
  endtask

  // Limit changes in the middle of a frame are deferred to the next frame start.
  task automatic test_midframe_limits();
    applyStimulus(1'b1, pk(1000, 10, 100, 500), 1'b1, 1'b0);
    tick();
    assertCount++; if (mTdata !== pk(960, 64, 100, 500)) begin failCount++; $display("[TB] FAIL limits_sof: got %h expected %h", mTdata, pk(960, 64, 100, 500)); end
    assertCount++; if (statValid !== 1'b1 || statLow !== 24'd3 || statHigh !== 24'd2) begin failCount++; $display("[TB] FAIL clamp_frame_stats: got v=%0b %0d/%0d expected v=1 3/2", statValid, statLow, statHigh); end
    clipMax = 10'd100;
    applyStimulus(1'b1, pk(1000, 10, 100, 500), 1'b0, 1'b1);
    tick();
    assertCount++; if (mTdata !== pk(960, 64, 100, 500)) begin failCount++; $display("[TB] FAIL limits_midframe: got %h expected %h", mTdata, pk(960, 64, 100, 500)); end
    applyStimulus(1'b1, pk(1000, 10, 100, 500), 1'b1, 1'b0);
    tick();
    assertCount++; if (mTdata !== pk(100, 64, 100, 100)) begin failCount++; $display("[TB] FAIL limits_new_frame: got %h expected %h", mTdata, pk(100, 64, 100, 100)); end
    assertCount++; if (statLow !== 24'd2 || statHigh !== 24'd2) begin failCount++; $display("[TB] FAIL limits_frame_stats: got %0d/%0d expected 2/2", statLow, statHigh); end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  // Continuous input while the output is stalled for five cycles. Beats must
  // leave in order, each exactly once, and the output must hold while stalled.
  task automatic test_back_to_back();
    int  sendIdx = 0;
    int  recvIdx = 0;
    int  cycle   = 0;
    logic modelValid = 1'b0;
    logic expReady;
    mode = 2'd0; clipMin = 10'd0; clipMax = 10'd1023;
    while (recvIdx < 12 && cycle < 100) begin
      mTready = (cycle >= 2 && cycle < 7) ? 1'b0 : 1'b1;
      applyStimulus(sendIdx < 12, pk(4*sendIdx, 4*sendIdx+1, 4*sendIdx+2, 4*sendIdx+3), sendIdx == 0, sendIdx == 11);
      #1;
      expReady = !modelValid || mTready;
      assertCount++; if (sTready !== expReady) begin failCount++; $display("[TB] FAIL bp_sready c%0d: got %0b expected %0b", cycle, sTready, expReady); end
      if (modelValid && mTready) begin
        assertCount++; if (mTdata !== pk(4*recvIdx, 4*recvIdx+1, 4*recvIdx+2, 4*recvIdx+3)) begin failCount++; $display("[TB] FAIL bp_order beat%0d: got %h expected %h", recvIdx, mTdata, pk(4*recvIdx, 4*recvIdx+1, 4*recvIdx+2, 4*recvIdx+3)); end
        recvIdx++;
      end
      if (expReady) begin
        if (sTvalid) sendIdx++;
        modelValid = sTvalid;
      end
      tick();
      assertCount++; if (mTvalid !== modelValid) begin failCount++; $display("[TB] FAIL bp_mvalid c%0d: got %0b expected %0b", cycle, mTvalid, modelValid); end
      if (modelValid && cycle >= 2 && cycle < 6) begin
        assertCount++; if (mTdata !== pk(4*recvIdx, 4*recvIdx+1, 4*recvIdx+2, 4*recvIdx+3)) begin failCount++; $display("[TB] FAIL bp_stall_hold c%0d: got %h expected %h", cycle, mTdata, pk(4*recvIdx, 4*recvIdx+1, 4*recvIdx+2, 4*recvIdx+3)); end
      end
      cycle++;
    end
    assertCount++; if (recvIdx != 12) begin failCount++; $display("[TB] FAIL bp_beats_delivered: got %0d expected 12", recvIdx); end
    mTready = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  // Counter saturation on the narrow instance, then a reset in the middle of a frame.
  task automatic test_saturation_reset();
    mode = 2'd1;
    applyStimulus(1'b1, pk(0, 0, 0, 0), 1'b1, 1'b0);
    tick();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, pk(0, 0, 0, 0), 1'b0, k == 3);
      tick();
    end
    applyStimulus(1'b1, pk(5, 5, 5, 5), 1'b1, 1'b0);
    tick();
    assertCount++; if (statLowSat !== 4'd15 || statHighSat !== 4'd0) begin failCount++; $display("[TB] FAIL sat_stats: got %0d/%0d expected 15/0", statLowSat, statHighSat); end
    assertCount++; if (statLow !== 24'd20) begin failCount++; $display("[TB] FAIL wide_stats: got %0d expected 20", statLow); end
    applyStimulus(1'b1, pk(0, 0, 0, 0), 1'b0, 1'b0);
    tick(); tick();
    areset = 1'b1;
    #1;
    assertCount++; if (mTvalid !== 1'b0 || mTvalidSat !== 1'b0) begin failCount++; $display("[TB] FAIL async_reset_mvalid: got %0b/%0b expected 0/0", mTvalid, mTvalidSat); end
    assertCount++; if (sTready !== 1'b1 || statLow !== 24'd0) begin failCount++; $display("[TB] FAIL async_reset_state: got sready=%0b low=%0d expected 1/0", sTready, statLow); end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
    areset = 1'b0;
    tick();
    assertCount++; if (mTvalid !== 1'b0) begin failCount++; $display("[TB] FAIL post_reset_idle: got %0b expected 0", mTvalid); end
    applyStimulus(1'b1, pk(0, 7, 7, 7), 1'b1, 1'b0);
    tick();
    assertCount++; if (statValid !== 1'b1 || statLow !== 24'd0 || statLowSat !== 4'd0) begin failCount++; $display("[TB] FAIL post_reset_first_sof: got v=%0b %0d/%0d expected v=1 0/0", statValid, statLow, statLowSat); end
    assertCount++; if (mTdata !== pk(1, 7, 7, 7)) begin failCount++; $display("[TB] FAIL post_reset_data: got %h expected %h", mTdata, pk(1, 7, 7, 7)); end
    applyStimulus(1'b1, pk(7, 7, 7, 7), 1'b1, 1'b0);
    tick();
    assertCount++; if (statLow !== 24'd1 || statLowSat !== 4'd1 || statHigh !== 24'd0) begin failCount++; $display("[TB] FAIL post_reset_frame_stats: got %0d/%0d high=%0d expected 1/1 high=0", statLow, statLowSat, statHigh); end
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    tick();
  endtask

  // Runs the scenarios in order, then prints the summary.
  initial begin
    test_reset();
    test_bypass();
    test_zero_replace();
    test_clamp();
    test_midframe_limits();
    test_back_to_back();
    test_saturation_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pixel_range_clamp.md
PIXEL_RANGE_CLAMP -- requirements
Module: pixel_range_clamp

Interface
REQ-001 Parameter CHANNELS, default 4, pixels per beat.
REQ-002 Parameter RAW_BITS, default 10, bits per pixel.
REQ-003 Parameter USER_BITS, default 1; tuser[0] is frame start.
REQ-004 Parameter COUNT_BITS, default 24, statistics counter width.
REQ-005 aclk  in  1  single clock; all logic on rising edge.
REQ-006 areset  in  1  asynchronous, active-high reset.
REQ-007 aclken  in  1  clock enable; when low all state holds.
REQ-008 mode  in  2  0=bypass, 1=zero-replace (0->1), 2/3=range clamp.
REQ-009 clip_min, clip_max  in  RAW_BITS each  clamp limits.
REQ-010 s_tuser/s_tlast/s_tdata/s_tvalid  in  USER_BITS/1/CHANNELS*RAW_BITS/1  input stream; pixel i at [i*RAW_BITS +: RAW_BITS].
REQ-011 s_tready  out  1  input ready.
REQ-012 m_tuser/m_tlast/m_tdata/m_tvalid  out  same widths  output stream.
REQ-013 m_tready  in  1  output ready.
REQ-014 stat_low, stat_high  out  COUNT_BITS each  clipped-pixel counts of last completed frame.
REQ-015 stat_valid  out  1  one-cycle pulse when stat_low/stat_high update.

Function
REQ-016 s_tready SHALL equal !m_tvalid || m_tready (combinational); a beat is accepted when aclken && s_tvalid && s_tready.
REQ-017 When aclken && s_tready, output registers SHALL load processed input and m_tvalid SHALL load s_tvalid; latency exactly 1 cycle.
REQ-018 While m_tvalid && !m_tready, m_* SHALL hold stable; no beat lost or duplicated.
REQ-019 mode, clip_min, clip_max SHALL be captured into shadow registers on accepted beat with s_tuser[0]=1 and on reset release; that beat and all following use shadow values; mid-frame changes ignored.
REQ-020 Reset values of shadows: mode=0, min=0, max=all ones.
REQ-021 Bypass: pixel passed unchanged, no counting.
REQ-022 Zero-replace: pixel 0 -> 1, counted low; others unchanged.
REQ-023 Clamp: v<min -> min (counted low); else v>max -> max (counted high); else unchanged. min>max thus yields min for v<min, max otherwise; defined, not an error.
REQ-024 tuser and tlast SHALL pass unchanged with the data.
REQ-025 Running counters cnt_low/cnt_high SHALL add, per accepted beat, the number of channels clipped low/high (0..CHANNELS), saturating at 2^COUNT_BITS-1.
REQ-026 On accepted beat with s_tuser[0]=1: stat_low/stat_high <= running counts before this beat; running counts <= this beat's contributions only; stat_valid=1 next cycle.
REQ-027 First frame start after reset SHALL also pulse stat_valid, reporting 0/0.
REQ-028 stat_valid SHALL be high for exactly one aclken cycle per frame start.

Reset
REQ-029 areset SHALL asynchronously clear m_tvalid, stat_valid, stat_low, stat_high, running counters; m_tdata/m_tuser/m_tlast reset to 0.
REQ-030 Reset mid-frame SHALL discard the in-flight beat and partial counts; first post-reset output only after a new accepted beat.
REQ-031 s_tready SHALL be 1 during and after reset (m_tvalid=0).

Verification
REQ-032 Bypass, RAW_BITS=10, beat {0,1,512,1023}, m_tready=1 -> same data next cycle, counts 0.
REQ-033 Zero-replace, beat {0,0,5,0} -> {1,1,5,1}; at next frame start stat_low=3, stat_high=0, stat_valid pulse.
REQ-034 Clamp min=64 max=960, frame of 2 beats {0,64,961,1023},{500,63,960,2} then frame start -> outputs {64,64,960,960},{500,64,960,64}; stat_low=3, stat_high=2.
REQ-035 Backpressure: m_tready low 5 cycles with continuous input -> m_tdata stable, s_tready low, no loss/duplication vs. reference model.
REQ-036 Change clip_max mid-frame from 960 to 100 -> no effect until next tuser[0] beat, which uses 100.
REQ-037 COUNT_BITS=4, 5 beats all-zero in zero-replace (20 clips) -> stat_low=15 (saturated); areset mid-frame -> m_tvalid=0 immediately, next frame reports only post-reset counts.
